// File: rtl/qpp_interleaver.sv
`default_nettype none
// ============================================================================
//  Module   : qpp_interleaver
//  Purpose  : Turbo-code style QPP interleaver with ping-pong bit banks.
//             Natural-order bits are written into one K-bit bank while the
//             other, already complete, bank is streamed out as (natural,
//             interleaved) bit pairs, one pair per cycle, with
//             pi(i) = (F1*i + F2*i*i) mod K generated recursively.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    K   block length in bits
//    F1  QPP linear coefficient
//    F2  QPP quadratic coefficient
//    AW  index width, 2^AW >= K
//  Ports
//    clk        in   rising-edge clock
//    reset      in   asynchronous active-high reset
//    bypass     in   (QPP_BYPASS_EN only) out_int mirrors out_nat while high
//    in_bit     in   natural-order data bit
//    in_valid   in   in_bit valid this cycle
//    in_ready   out  write bank can accept in_bit this cycle
//    out_nat    out  natural-order bit (first RSC encoder)
//    out_int    out  interleaved bit (second RSC encoder)
//    out_valid  out  out_nat / out_int valid
//    out_start  out  output index 0 of a block
//    out_last   out  output index K-1 of a block
//  Build option
//    QPP_BYPASS_EN  adds the bypass input; without it interleaving is always
//                   active and the port is absent.
// ============================================================================
module qpp_interleaver #(
  parameter int K  = 40,
  parameter int F1 = 3,
  parameter int F2 = 10,
  parameter int AW = 6
) (
  input  logic clk,
  input  logic reset,
`ifdef QPP_BYPASS_EN
  input  logic bypass,
`endif
  input  logic in_bit,
  input  logic in_valid,
  output logic in_ready,
  output logic out_nat,
  output logic out_int,
  output logic out_valid,
  output logic out_start,
  output logic out_last
);

  // Index constants, all pre-reduced modulo K so the recursion only ever
  // needs a single conditional subtract per addition.
  localparam logic [AW:0]   K_EXT  = (AW+1)'(K);
  localparam logic [AW-1:0] LAST   = AW'(K - 1);
  localparam logic [AW-1:0] G0     = AW'((F1 + F2) % K);
  localparam logic [AW-1:0] TWO_F2 = AW'((2 * F2) % K);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // (a + b) mod K for a, b already in [0, K).
  function automatic logic [AW-1:0] add_mod(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= K_EXT) s = s - K_EXT;
    return s[AW-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Storage and control state
  // --------------------------------------------------------------------------
  logic [K-1:0]  bank0;
  logic [K-1:0]  bank1;
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          wbank;
  logic          rbank;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] ridx;
  logic [AW-1:0] pi_idx;
  logic [AW-1:0] g_step;
  state_t        state;

  logic          wr_en;
  logic          wr_done;
  logic          rd_done;
  logic [K-1:0]  rd_bank;
  logic          nat_bit;
  logic          int_bit;

  assign in_ready = ~full[wbank];
  assign wr_en    = in_valid & in_ready;
  assign wr_done  = wr_en & (wcnt == LAST);
  assign rd_done  = (state == READ) & (ridx == LAST);

  // Write and read banks are always distinct while both are active: the
  // write bank is never full, the read bank always is.
  assign rd_bank  = rbank ? bank1 : bank0;
  assign nat_bit  = rd_bank[ridx];

`ifdef QPP_BYPASS_EN
  assign int_bit  = bypass ? rd_bank[ridx] : rd_bank[pi_idx];
`else
  assign int_bit  = rd_bank[pi_idx];
`endif

  // Set by the writer, cleared by the reader; the two events target
  // different banks so both can land on the same edge.
  always_comb begin
    full_nxt = full;
    if (wr_done) full_nxt[wbank] = 1'b1;
    if (rd_done) full_nxt[rbank] = 1'b0;
  end

  // --------------------------------------------------------------------------
  // Bank storage: data content is don't-care until the full flag is set, so
  // it carries no reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wbank) bank1[wcnt] <= in_bit;
      else       bank0[wcnt] <= in_bit;
    end
  end

  // --------------------------------------------------------------------------
  // Writer: fill counter, bank pointer and full flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full  <= 2'b00;
      wbank <= 1'b0;
      wcnt  <= '0;
    end else begin
      full <= full_nxt;
      if (wr_en) begin
        if (wcnt == LAST) begin
          wcnt  <= '0;
          wbank <= ~wbank;
        end else begin
          wcnt  <= wcnt + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Reader FSM with registered outputs. Outputs default to zero every cycle
  // so that they are only non-zero alongside out_valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rbank     <= 1'b0;
      ridx      <= '0;
      pi_idx    <= '0;
      g_step    <= '0;
      out_valid <= 1'b0;
      out_nat   <= 1'b0;
      out_int   <= 1'b0;
      out_start <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_nat   <= 1'b0;
      out_int   <= 1'b0;
      out_start <= 1'b0;
      out_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (full[rbank]) begin
            state  <= READ;
            ridx   <= '0;
            pi_idx <= '0;
            g_step <= G0;
          end
        end
        READ: begin
          out_valid <= 1'b1;
          out_nat   <= nat_bit;
          out_int   <= int_bit;
          out_start <= (ridx == '0);
          out_last  <= (ridx == LAST);
          if (ridx == LAST) begin
            rbank  <= ~rbank;
            ridx   <= '0;
            pi_idx <= '0;
            g_step <= G0;
            // The other bank's flag is sampled before this edge: a block
            // completing on this very edge is picked up from IDLE instead.
            if (!full[~rbank]) state <= IDLE;
          end else begin
            ridx   <= ridx + 1'b1;
            pi_idx <= add_mod(pi_idx, g_step);
            g_step <= add_mod(g_step, TWO_F2);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qpp_interleaver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_qpp_interleaver
//  Purpose  : Directed self-checking bench for qpp_interleaver (K=40, F1=3,
//             F2=10). Output pairs are captured by a negedge monitor and
//             compared against hand-computed bit positions and a direct
//             pi(i) = (F1*i + F2*i*i) mod K reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_qpp_interleaver;

  localparam int K  = 40;
  localparam int F1 = 3;
  localparam int F2 = 10;
  localparam int AW = 6;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic in_bit   = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic out_nat;
  logic out_int;
  logic out_valid;
  logic out_start;
  logic out_last;
`ifdef QPP_BYPASS_EN
  logic bypass   = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic cap_nat[$];
  logic cap_int[$];
  logic cap_start[$];
  logic cap_last[$];
  int   start_cycs[$];
  int   low_run  = 0;
  int   max_low  = 0;
  int   idle_bad = 0;
  int   last_accept_cyc = 0;

  qpp_interleaver #(.K(K), .F1(F1), .F2(F2), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef QPP_BYPASS_EN
    .bypass    (bypass),
`endif
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_nat   (out_nat),
    .out_int   (out_int),
    .out_valid (out_valid),
    .out_start (out_start),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Output monitor, sampled half a cycle away from the active edge.
  always @(negedge clk) begin
    if (out_valid) begin
      cap_nat.push_back(out_nat);
      cap_int.push_back(out_int);
      cap_start.push_back(out_start);
      cap_last.push_back(out_last);
      if (out_start) start_cycs.push_back(cyc);
    end else if (out_nat || out_int || out_start || out_last) begin
      idle_bad++;
    end
    if (!in_ready) low_run++;
    else           low_run = 0;
    if (low_run > max_low) max_low = low_run;
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_pi(input int i);
    return (F1 * i + F2 * i * i) % K;
  endfunction

  task automatic clear_mon();
    cap_nat.delete();
    cap_int.delete();
    cap_start.delete();
    cap_last.delete();
    start_cycs.delete();
    low_run = 0;
    max_low = 0;
  endtask

  // Presents bits lo..hi of d; the caller ends the burst with stop_in().
  task automatic send_bits(input logic [K-1:0] d, input bit gapped,
                           input int lo, input int hi);
    int i = lo;
    int n = 0;
    while (i <= hi && n < 1000) begin
      @(negedge clk);
      n++;
      if (gapped && (n % 3 == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_bit   = d[i];
        if (in_ready) begin
          if (i == K - 1) last_accept_cyc = cyc + 1;
          i++;
        end
      end
    end
    check("send_done", 64'(i), 64'(hi + 1));
  endtask

  task automatic stop_in();
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic wait_out(input int n, input int budget);
    int b = 0;
    while (cap_nat.size() < n && b < budget) begin
      @(negedge clk);
      #1;
      b++;
    end
  endtask

  task automatic gather(input int base, output logic [63:0] nv,
                        output logic [63:0] iv, output logic [63:0] sv,
                        output logic [63:0] lv);
    nv = '0; iv = '0; sv = '0; lv = '0;
    for (int j = 0; j < K; j++) begin
      if (base + j < cap_nat.size()) begin
        nv[j] = cap_nat[base + j];
        iv[j] = cap_int[base + j];
        sv[j] = cap_start[base + j];
        lv[j] = cap_last[base + j];
      end
    end
  endtask

  initial begin
    logic [K-1:0]  d;
    logic [K-1:0]  blk [3];
    logic [63:0]   r;
    logic [63:0]   nv, iv, sv, lv;
    int            lat;
    int            nat_bad;
    int            int_bad;

    // ---------------- reset with no input ----------------
    repeat (2) @(negedge clk);
    check("rst_outs_during", 64'({out_valid, out_nat, out_int, out_start, out_last}), 64'd0);
    check("rst_ready_during", 64'(in_ready), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check("rst_outs", 64'({out_valid, out_nat, out_int, out_start, out_last}), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    repeat (100) @(negedge clk);
    check("idle_no_valid", 64'(cap_nat.size()), 64'd0);

    // ---------------- single 1 at index 13, consecutive ----------------
    clear_mon();
    d = '0;
    d[13] = 1'b1;
    send_bits(d, 1'b0, 0, K - 1);
    stop_in();
    wait_out(K, 300);
    repeat (5) @(negedge clk);
    check("b13_count", 64'(cap_nat.size()), 64'(K));
    gather(0, nv, iv, sv, lv);
    check("b13_nat",   nv, 64'h0000_0000_2000);
    check("b13_int",   iv, 64'h0000_0000_0002);
    check("b13_start", sv, 64'h0000_0000_0001);
    check("b13_last",  lv, 64'h0080_0000_0000);
    lat = (start_cycs.size() > 0) ? start_cycs[0] - last_accept_cyc : -1;
    check("b13_latency", 64'(lat), 64'd2);

    // ---------------- single 1 at index 25, gapped input ----------------
    clear_mon();
    d = '0;
    d[25] = 1'b1;
    send_bits(d, 1'b1, 0, K - 1);
    stop_in();
    wait_out(K, 300);
    repeat (5) @(negedge clk);
    check("b25_count", 64'(cap_nat.size()), 64'(K));
    gather(0, nv, iv, sv, lv);
    check("b25_nat", nv, 64'h0000_0200_0000);
    check("b25_int", iv, 64'h0000_0000_0020);

    // ---------------- three random blocks, in_valid held ----------------
    clear_mon();
    for (int b = 0; b < 3; b++) begin
      r = {$urandom(), $urandom()};
      blk[b] = r[K-1:0];
    end
    for (int b = 0; b < 3; b++) send_bits(blk[b], 1'b0, 0, K - 1);
    stop_in();
    wait_out(3 * K, 600);
    repeat (5) @(negedge clk);
    check("x3_valid_cycles", 64'(cap_nat.size()), 64'(3 * K));
    check("x3_start_pulses", 64'(start_cycs.size()), 64'd3);
    nat_bad = 0;
    int_bad = 0;
    for (int n = 0; n < 3 * K; n++) begin
      if (n < cap_nat.size()) begin
        if (cap_nat[n] !== blk[n / K][n % K])         nat_bad++;
        if (cap_int[n] !== blk[n / K][ref_pi(n % K)]) int_bad++;
      end
    end
    check("x3_nat_errors", 64'(nat_bad), 64'd0);
    check("x3_int_errors", 64'(int_bad), 64'd0);
    lat = (start_cycs.size() > 1) ? start_cycs[1] - start_cycs[0] : -1;
    check("x3_back_to_back", 64'(lat), 64'(K));
    check("x3_ready_low_gt2", 64'(max_low > 2), 64'd0);

    // ---------------- asynchronous reset mid-read ----------------
    clear_mon();
    d = '0;
    d[7] = 1'b1;
    send_bits(d, 1'b0, 0, K - 1);
    stop_in();
    wait_out(21, 300);
    check("rr_reached_idx20", 64'(cap_nat.size()), 64'd21);
    #1;
    reset = 1'b1;
    #1;
    check("rr_outs_async", 64'({out_valid, out_nat, out_int, out_start, out_last}), 64'd0);
    check("rr_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    repeat (100) @(negedge clk);
    check("rr_no_valid", 64'(cap_nat.size()), 64'd0);
    d = '0;
    d[13] = 1'b1;
    send_bits(d, 1'b0, 0, K - 2);
    stop_in();
    repeat (60) @(negedge clk);
    check("rr_partial_held", 64'(cap_nat.size()), 64'd0);
    send_bits(d, 1'b0, K - 1, K - 1);
    stop_in();
    wait_out(K, 300);
    repeat (5) @(negedge clk);
    check("rr_fresh_count", 64'(cap_nat.size()), 64'(K));
    gather(0, nv, iv, sv, lv);
    check("rr_fresh_nat", nv, 64'h0000_0000_2000);
    check("rr_fresh_int", iv, 64'h0000_0000_0002);

`ifdef QPP_BYPASS_EN
    // ---------------- bypass: out_int mirrors out_nat ----------------
    clear_mon();
    bypass = 1'b1;
    send_bits(d, 1'b0, 0, K - 1);
    stop_in();
    wait_out(K, 300);
    repeat (5) @(negedge clk);
    bypass = 1'b0;
    check("byp_count", 64'(cap_nat.size()), 64'(K));
    gather(0, nv, iv, sv, lv);
    check("byp_nat", nv, 64'h0000_0000_2000);
    check("byp_int", iv, 64'h0000_0000_2000);
`endif

    check("idle_outputs_zero", 64'(idle_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
